// File: rtl/layer_backward.sv
// layer_backward: sequential Q8.8 backward pass computing dx = W^T*dy, dw = dy*x^T, db = dy.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   start_i               : begin a pass (sampled only while idle)
//   x_i, w_i, dy_i        : layer input, weights (neuron i owns word block i), upstream gradient
//   dx_o, dw_o, db_o      : input, weight and bias gradients, held until the next pass
//   busy_o, done_o        : pass in progress; one-cycle completion pulse
module layer_backward #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [N*16-1:0]   x_i,
  input  logic [M*N*16-1:0] w_i,
  input  logic [M*16-1:0]   dy_i,
  output logic [N*16-1:0]   dx_o,
  output logic [M*N*16-1:0] dw_o,
  output logic [M*16-1:0]   db_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int IW = M > 1 ? $clog2(M) : 1;
  localparam int JW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [N*16-1:0] x_q, dx_q;
  logic [M*N*16-1:0] w_q, dw_q;
  logic [M*16-1:0] dy_q, db_q;
  logic [IW-1:0] i_q;
  logic [JW-1:0] j_q;
  logic signed [39:0] acc_q [N];
  logic done_q, last_j, last;
  logic signed [15:0] dy_w, w_w, x_w;
  logic signed [31:0] p_dx, p_dw;
  function automatic logic [15:0] sat(input logic signed [39:0] v);
    return v > 40'sd32767 ? 16'h7fff : v < -40'sd32768 ? 16'h8000 : v[15:0];
  endfunction
  assign dy_w = dy_q[16*int'(i_q) +: 16];
  assign w_w = w_q[16*(N*int'(i_q) + int'(j_q)) +: 16];
  assign x_w = x_q[16*int'(j_q) +: 16];
  assign p_dx = dy_w * w_w;
  assign p_dw = dy_w * x_w;
  assign last_j = j_q == JW'(N - 1);
  assign last = last_j && i_q == IW'(M - 1);
  always_comb
    state_d = state_q == IDLE ? (start_i ? RUN : IDLE) : state_q == RUN ? (last ? FIN : RUN) : IDLE;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x_q <= '0;
      w_q <= '0;
      dy_q <= '0;
      dx_q <= '0;
      dw_q <= '0;
      db_q <= '0;
      i_q <= '0;
      j_q <= '0;
      done_q <= 1'b0;
      for (int k = 0; k < N; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      done_q <= state_q == FIN;
      if (state_q == IDLE && start_i) begin
        x_q <= x_i;
        w_q <= w_i;
        dy_q <= dy_i;
        i_q <= '0;
        j_q <= '0;
        for (int k = 0; k < N; k++) acc_q[k] <= '0;
      end
      if (state_q == RUN) begin
        acc_q[j_q] <= acc_q[j_q] + 40'(p_dx);
        dw_q[16*(N*int'(i_q) + int'(j_q)) +: 16] <= sat(40'(p_dw) >>> 8);
        j_q <= last_j ? '0 : j_q + 1'b1;
        i_q <= last_j ? i_q + 1'b1 : i_q;
      end
      if (state_q == FIN) begin
        for (int k = 0; k < N; k++) dx_q[16*k +: 16] <= sat(acc_q[k] >>> 8);
        db_q <= dy_q;
      end
    end
  end
  assign dx_o = dx_q;
  assign dw_o = dw_q;
  assign db_o = db_q;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
endmodule

// File: tb/tb_layer_backward.sv
// tb_layer_backward: scoreboard bench for layer_backward with directed, hand-computed vectors.
module tb_layer_backward;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic s2 = 1'b0, s4 = 1'b0;
  logic [31:0] x2 = '0, dy2 = '0, dx2, db2;
  logic [63:0] w2 = '0, dw2;
  logic [63:0] x4 = '0, dy4 = '0, dx4, db4;
  logic [255:0] w4 = '0, dw4;
  logic busy2, done2, busy4, done4;
  typedef struct {
    logic [63:0] dx;
    logic [255:0] dw;
    logic [63:0] db;
  } exp_t;
  exp_t q2[$], q4[$];
  int total = 0, bad = 0, ndone4 = 0;
  layer_backward #(.N(2), .M(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s2), .x_i(x2), .w_i(w2), .dy_i(dy2),
    .dx_o(dx2), .dw_o(dw2), .db_o(db2), .busy_o(busy2), .done_o(done2)
  );
  layer_backward #(.N(4), .M(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s4), .x_i(x4), .w_i(w4), .dy_i(dy4),
    .dx_o(dx4), .dw_o(dw4), .db_o(db4), .busy_o(busy4), .done_o(done4)
  );
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      ndone4++;
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done4: unexpected done pulse");
      end else begin
        e = q4.pop_front();
        chk("dx4", dx4, e.dx);
        chk("dw4", dw4, e.dw);
        chk("db4", db4, e.db);
      end
    end
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done2: unexpected done pulse");
      end else begin
        e = q2.pop_front();
        chk("dx2", dx2, e.dx[31:0]);
        chk("dw2", dw2, e.dw[63:0]);
        chk("db2", db2, e.db[31:0]);
      end
    end
  end
  task automatic go4(input logic [63:0] x, input logic [255:0] w, input logic [63:0] dy,
                     input logic [63:0] edx, input logic [255:0] edw, input int mode);
    int cyc, nd;
    bit bz;
    q4.push_back('{edx, edw, dy});
    @(negedge clk);
    x4 = x;
    w4 = w;
    dy4 = dy;
    s4 = 1'b1;
    @(posedge clk);
    #1;
    s4 = 1'b0;
    cyc = 0;
    bz = 1'b1;
    nd = ndone4;
    while (!done4 && cyc < 40) begin
      if (mode == 1) begin
        x4 = ~{x4[62:0], x4[63]};
        w4 = {w4[254:0], ~w4[255]} ^ 256'h1357;
        dy4 = dy4 + 64'h0123_4567_89ab_cdef;
      end
      if (mode == 2 && cyc == 5) begin
        s4 = 1'b1;
        x4 = {4{16'h7fff}};
        w4 = {16{16'h7fff}};
        dy4 = {4{16'h7fff}};
      end else s4 = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (!done4 && !busy4) bz = 1'b0;
    end
    s4 = 1'b0;
    chk("latency4", cyc, 17);
    chk("busy4 during pass", bz, 1);
    chk("busy4 at done", busy4, 0);
    repeat (mode == 2 ? 20 : 2) @(posedge clk);
    #1;
    chk("done4 count", ndone4 - nd, 1);
    chk("busy4 idle", busy4, 0);
  endtask
  initial begin
    int cyc;
    #1 rst_n = 1'b0;
    #11;
    chk("rst dx4", dx4, 0);
    chk("rst dw4", dw4, 0);
    chk("rst db4", db4, 0);
    chk("rst busy4", busy4, 0);
    chk("rst done4", done4, 0);
    chk("rst dx2", dx2, 0);
    chk("rst dw2", dw2, 0);
    chk("rst busy2", busy2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // identity weights, N=M=2
    q2.push_back('{64'h0000_0000_ff00_0080, 256'hfe00_ff00_0100_0080, 64'h0000_0000_ff00_0080});
    @(negedge clk);
    x2 = 32'h0200_0100;
    dy2 = 32'hff00_0080;
    w2 = 64'h0100_0000_0000_0100;
    s2 = 1'b1;
    @(posedge clk);
    #1;
    s2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency2", cyc, 5);
    @(posedge clk);
    // saturation high / low, floor truncation
    go4({4{16'h7fff}}, {16{16'h7fff}}, {4{16'h7fff}}, {4{16'h7fff}}, {16{16'h7fff}}, 0);
    go4({4{16'h7fff}}, {16{16'h7fff}}, {4{16'h8000}}, {4{16'h8000}}, {16{16'h8000}}, 0);
    go4({4{16'h0080}}, {16{16'h0080}}, {4{16'hffff}}, {4{16'hfffe}}, {16{16'hffff}}, 0);
    // mixed signs with a start pulse mid-run carrying other operands
    go4(64'h0080_ff00_0200_0100, {16{16'h0100}}, 64'hff00_0000_0200_0100, {4{16'h0200}},
        {64'hff80_0100_fe00_ff00, 64'h0, 64'h0100_fe00_0400_0200, 64'h0080_ff00_0200_0100}, 2);
    // reset in the middle of a run
    @(negedge clk);
    x4 = {4{16'h0100}};
    w4 = {16{16'h0100}};
    dy4 = {4{16'h0100}};
    s4 = 1'b1;
    @(posedge clk);
    #1;
    s4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst dx4", dx4, 0);
    chk("midrst dw4", dw4, 0);
    chk("midrst db4", db4, 0);
    chk("midrst busy4", busy4, 0);
    chk("midrst done4", done4, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // fresh pass, non-symmetric weights, inputs scrambled after start
    go4({4{16'h0100}}, {{12{16'h0500}}, 64'h0400_0300_0200_0100}, 64'h0000_0000_0000_0100,
        64'h0400_0300_0200_0100, {192'h0, {4{16'h0100}}}, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("q4 drained", q4.size(), 0);
    chk("q2 drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/layer_backward.md
# layer_backward

Backward-pass companion to the forward `layer` block. Given the layer input `x`, weights `w` and upstream gradient `dy`, it computes the three gradients below in signed Q8.8 fixed point, using a sequential two-multiplier datapath.
- Input gradient: `dx = Wᵀ·dy`.
- Weight gradient: `dw = dy·xᵀ`.
- Bias gradient: `db = dy`.

It sits beside each `layer` instance in the training path. It uses the same operand packing and start/done handshake as the forward block.

## Interface
Parameters:
- `N`, default 4: inputs per neuron (width of `x` and `dx` in 16-bit words).
- `M`, default 4: neurons in the layer (width of `dy` and `db` in words).

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a pass. Sampled only while idle.
- `x`, input, N*16: layer input. Word j is at bits [16j+15:16j].
- `w`, input, M*N*16: weights. Word (i,j) is at bits [16(iN+j)+15 : 16(iN+j)], so neuron i owns the slice [16N(i+1)-1 : 16Ni].
- `dy`, input, M*16: upstream gradient. Word i is at bits [16i+15:16i].
- `dx`, output, N*16: input gradient. Same packing as `x`.
- `dw`, output, M*N*16: weight gradient. Same packing as `w`.
- `db`, output, M*16: bias gradient. Same packing as `dy`.
- `busy`, output, 1: high from the cycle after `start` is accepted until `done` rises.
- `done`, output, 1: single-cycle pulse when all outputs are valid.

## Operation
Fixed-point format:
- All operands and results are signed Q8.8, so 0x0100 = 1.0.
- A product is the full 32-bit signed result, arithmetically shifted right by 8 (floor, no rounding).
- Saturation clamps a value to [0x8000, 0x7FFF].

State machine:
- **IDLE**: when `start`=1, latch `x`, `w` and `dy` into internal registers and clear the N `dx` accumulators. Then move to RUN with i=0, j=0.
- **RUN**: each cycle handles one pair (i,j).
  - `dxacc[j] += dy[i]*w[i][j]`. The accumulator is 40-bit signed and holds the unshifted 32-bit product sum.
  - `dw[i][j] <= sat(dy[i]*x[j] >>> 8)`.
  - j increments fastest. When j=N-1, j wraps to 0 and i increments.
  - After pair (M-1, N-1), move to FIN.
- **FIN**: `dx[j] <= sat(dxacc[j] >>> 8)` for every j. `db <= latched dy`. Pulse `done`, clear `busy`, return to IDLE.

Rules:
- Inputs may change freely after the `start` cycle. Only the latched copies are used.
- `start` is ignored while in RUN or FIN. No queuing.
- `start` asserted on the same cycle as `done` is accepted only if it is still high in the following IDLE cycle.
- Outputs hold their last values until the next pass overwrites them.
- `dw` words update progressively during RUN. Only the `done` pulse guarantees that all outputs are coherent.

## Timing
Reset (asynchronous, `rst_n`=0):
- State goes to IDLE.
- `dx`, `dw`, `db`, accumulators and counters go to 0.
- `busy` and `done` go to 0.
- Reset may be applied mid-pass. It aborts immediately with no `done`.

Pass timing, for `start` sampled at rising edge E0:
- `busy`=1 after E0.
- RUN covers edges E1 through E(MN).
- FIN executes at edge E(MN+1), after which `done`=1 and `busy`=0.
- `done` falls at E(MN+2).
- Latency from start to done is MN+1 cycles. For the defaults this is 17.
- The earliest next `start` is sampled at E(MN+2).

## Test plan
- **Identity weights**: N=M=2, x={0x0100, 0x0200}, dy={0x0080, 0xFF00}, w=identity (0x0100 on diagonal).
  - dx={0x0080, 0xFF00}.
  - dw={0x0080, 0x0100, 0xFF00, 0xFE00} in (i,j) order.
  - db=dy.
  - `done` high exactly 5 cycles after the start edge.
- **Saturation**: defaults, all w=0x7FFF, all dy=0x7FFF, x=0x7FFF.
  - Every dx word is 0x7FFF and every dw word is 0x7FFF.
  - Repeat with dy=0x8000: dx and dw are all 0x8000.
- **Floor truncation**: dy=0xFFFF (−1/256), x=0x0080, w=0x0080.
  - dw=0xFFFF.
  - dx=0xFFFF×M, summed before the shift: for M=4 this is −512/256, so dx=0xFFFE.
- **Start while busy**: pulse `start` with new operands mid-RUN.
  - Results match the original operands.
  - Exactly one `done`.
  - `busy` stays high throughout.
- **Reset mid-pass**: assert `rst_n`=0 at RUN cycle 3.
  - All outputs are 0 immediately.
  - No `done`.
  - A fresh pass afterwards produces correct results.
- **Input changes after start**: change x, w and dy every cycle after start.
  - Outputs equal the values computed from the operands present at the start edge.
